alu_exec_ctrl: RTL and testbench

//  Sequencer and register stage wrapped around the 8-bit ALU. Sits directly upstream and downstream of it.

---
 rtl/alu_exec_ctrl_pkg.sv | 32 +++
 rtl/alu_regfile.sv | 43 ++++
 rtl/alu_exec_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_ctrl_pkg
// Shared definitions for the ALU execute/writeback controller:
//   - instruction opcodes
//   - sequencer state encoding
//   - bit positions inside the {N,Z,V,C} flag register
//   - default data width and register-file depth
// ---------------------------------------------------------------------------
package alu_exec_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NREGS_DEF  = 4;

  typedef enum logic [1:0] {
    OP_ALU_RR = 2'b00,  // rd = alu(reg[rs1], reg[rs2])
    OP_ALU_RI = 2'b01,  // rd = alu(reg[rs1], imm)
    OP_LDI    = 2'b10,  // rd = imm
    OP_RD     = 2'b11   // return reg[rs1], no write
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage : alu_exec_ctrl_pkg

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// NREGS x DATA_W register file, cleared by the asynchronous reset.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   we, waddr, wdata   single synchronous write port
//   raddr_a / rdata_a  combinational read port A
//   raddr_b / rdata_b  combinational read port B
// ---------------------------------------------------------------------------
module alu_regfile #(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 4,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];

  // NOTE: the array is reset on purpose: an abandoned instruction must leave a
  // known all-zero register file, so this stays flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule : alu_regfile

// File: rtl/alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// alu_exec_ctrl
// Sequencer and register stage wrapped around an external 8-bit ALU.
// One instruction per valid/ready handshake, IDLE -> EXEC -> WB -> IDLE.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (ready only in IDLE)
//   instr_op/sel/rd/rs1/rs2/imm  instruction fields
//   alu_a, alu_b, alu_s      registered ALU operands/select (change on accept)
//   alu_out, alu_c/z/v/n     ALU result and flags (combinational from alu_a/b/s)
//   res_valid                one-cycle pulse after writeback
//   res_data                 value written to rd, or read value for RD
//   flags                    {N,Z,V,C} flag register
// ---------------------------------------------------------------------------
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NREGS  = NREGS_DEF,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [2:0]        instr_sel,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_s,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_n,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        flags
);

  state_e            state_q, state_d;
  logic              accept;
  logic              wb;
  op_e               op_q;
  logic [REG_AW-1:0] rd_q;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wb = (state_q == ST_WB);

  // ---------------- register file ----------------
  // LDI's immediate already travels on alu_b, so it doubles as the write data.
  assign rf_we    = wb && (op_q != OP_RD);
  assign rf_wdata = (op_q == OP_LDI) ? alu_b : alu_out;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (rf_wdata),
    .raddr_a (instr_rs1),
    .rdata_a (rf_rdata_a),
    .raddr_b (instr_rs2),
    .rdata_b (rf_rdata_b)
  );

  // ---------------- operand latch ----------------
  // Operands are captured at accept, so rd == rs1/rs2 reads the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_ALU_RR;
      rd_q  <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_s <= '0;
    end else if (accept) begin
      op_q  <= op_e'(instr_op);
      rd_q  <= instr_rd;
      alu_a <= rf_rdata_a;
      alu_b <= (instr_op == OP_ALU_RR) ? rf_rdata_b : instr_imm;
      alu_s <= instr_sel;
    end
  end

  // ---------------- result and flags ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      flags     <= '0;
    end else begin
      res_valid <= wb;
      if (wb) begin
        unique case (op_q)
          OP_ALU_RR, OP_ALU_RI: begin
            res_data <= alu_out;
            flags    <= {alu_n, alu_z, alu_v, alu_c};
          end
          OP_LDI: begin
            // V and C are left as the last ALU op produced them.
            res_data      <= alu_b;
            flags[FLAG_N] <= alu_b[DATA_W-1];
            flags[FLAG_Z] <= (alu_b == '0);
          end
          OP_RD: begin
            res_data <= alu_a;
          end
          default: ;
        endcase
      end
    end
  end

endmodule : alu_exec_ctrl

// File: tb/tb_alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_ctrl
// Drives alu_exec_ctrl with an 8-bit ALU attached and compares every result
// pulse against a reference model of the architectural state (register array
// and flags) updated once per accepted instruction.
// ALU selects: 000 add, 001 sub, 010 inc a, 011 dec a,
//              100 and, 101 or, 110 xor, 111 not a.
// ---------------------------------------------------------------------------
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_op;
  logic [2:0] instr_sel;
  logic [1:0] instr_rd, instr_rs1, instr_rs2;
  logic [7:0] instr_imm;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_s;
  logic       alu_c, alu_z, alu_v, alu_n;
  logic       res_valid;
  logic [7:0] res_data;
  logic [3:0] flags;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_exec_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_sel   (instr_sel),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .instr_imm   (instr_imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_s       (alu_s),
    .alu_out     (alu_out),
    .alu_c       (alu_c),
    .alu_z       (alu_z),
    .alu_v       (alu_v),
    .alu_n       (alu_n),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .flags       (flags)
  );

  // ---------------- 8-bit ALU ----------------
  typedef struct packed {
    logic [7:0] o;
    logic       c, z, v, n;
  } alu_r_t;

  function automatic alu_r_t alu_f(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] s);
    alu_r_t r;
    logic [8:0] w;
    r = '0;
    case (s)
      3'b000: begin w = {1'b0, a} + {1'b0, b}; r.o = w[7:0]; r.c = w[8];
                r.v = (a[7] == b[7]) && (r.o[7] != a[7]); end
      3'b001: begin r.o = a - b; r.c = (a < b);
                r.v = (a[7] != b[7]) && (r.o[7] != a[7]); end
      3'b010: begin r.o = a + 8'd1; r.c = (a == 8'hFF); r.v = (a == 8'h7F); end
      3'b011: begin r.o = a - 8'd1; r.c = (a == 8'h00); r.v = (a == 8'h80); end
      3'b100: r.o = a & b;
      3'b101: r.o = a | b;
      3'b110: r.o = a ^ b;
      default: r.o = ~a;
    endcase
    r.z = (r.o == 8'h00);
    r.n = r.o[7];
    return r;
  endfunction

  always_comb begin
    alu_r_t r;
    r       = alu_f(alu_a, alu_b, alu_s);
    alu_out = r.o;
    alu_c   = r.c;
    alu_z   = r.z;
    alu_v   = r.v;
    alu_n   = r.n;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] data;
    logic [3:0] flg;
    int         acc_cyc;
  } exp_t;

  logic [7:0] m_reg [4];
  logic [3:0] m_flags;   // {N,Z,V,C}
  exp_t       exp_q [$];
  int         acc_q [$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_flags = 4'h0;
    exp_q.delete();
  endtask

  // Result pulses: each must match the oldest outstanding instruction and
  // arrive two edges after its accept edge.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      check("pulse_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_data", res_data, e.data);
        check("flags", flags, e.flg);
        check("latency", cyc, e.acc_cyc + 2);
      end
    end
  end

  // Called at a negedge. Presents one instruction, waits for acceptance,
  // updates the model, and returns at the negedge where the stage is idle again
  // (or right after the mid-EXEC reset when abort is set).
  task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm,
                       input bit keep_valid, input bit abort);
    logic [7:0] a, b;
    alu_r_t     r;
    exp_t       e;
    int         n;
    instr_op    = op;
    instr_sel   = sel;
    instr_rd    = rd;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
    instr_imm   = imm;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      check("accept_timeout", 32'(instr_ready), 1);
      instr_valid = 1'b0;
      return;
    end
    a = m_reg[rs1];
    b = (op == 2'b00) ? m_reg[rs2] : imm;
    e.acc_cyc = cyc + 1;
    case (op)
      2'b00, 2'b01: begin
        r         = alu_f(a, b, sel);
        m_reg[rd] = r.o;
        m_flags   = {r.n, r.z, r.v, r.c};
        e.data    = r.o;
      end
      2'b10: begin
        m_reg[rd]  = imm;
        m_flags[3] = imm[7];
        m_flags[2] = (imm == 8'h00);
        e.data     = imm;
      end
      default: e.data = a;
    endcase
    e.flg = m_flags;
    exp_q.push_back(e);
    acc_q.push_back(e.acc_cyc);
    @(posedge clk);
    @(negedge clk);
    check("rdy_exec", instr_ready, 0);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_s", alu_s, sel);
    if (!keep_valid) instr_valid = 1'b0;
    if (abort) begin
      instr_valid = 1'b0;
      rst = 1'b1;
      #2 rst = 1'b0;
      model_reset();
      return;
    end
    @(negedge clk);
    check("rdy_wb", instr_ready, 0);
    @(negedge clk);
    check("rdy_idle", instr_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_sel   = '0;
    instr_rd    = '0;
    instr_rs1   = '0;
    instr_rs2   = '0;
    instr_imm   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_ready", instr_ready, 1);
    check("rst_valid", res_valid, 0);
    check("rst_flags", flags, 4'h0);
    check("rst_data", res_data, 8'h00);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_s", alu_s, 3'b000);

    // 1. reset mid-EXEC abandons LDI r1=0x55
    issue(2'b10, 3'b000, 2'd1, 2'd0, 2'd0, 8'h55, 1'b0, 1'b1);
    @(negedge clk);
    check("t1_flags", flags, 4'h0);
    check("t1_data", res_data, 8'h00);
    check("t1_ready", instr_ready, 1);
    repeat (3) @(negedge clk);
    issue(2'b11, 3'b000, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 1'b0);
    check("t1_rd_r1", res_data, 8'h00);
    check("t1_rd_flags", flags, 4'h0);

    // 2. 0x7F + 0x01 -> 0x80, N=1 Z=0 V=1 C=0
    issue(2'b10, 3'b000, 2'd1, 2'd0, 2'd0, 8'h7F, 1'b0, 1'b0);
    issue(2'b10, 3'b000, 2'd2, 2'd0, 2'd0, 8'h01, 1'b0, 1'b0);
    issue(2'b00, 3'b000, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0, 1'b0);
    check("t2_data", res_data, 8'h80);
    check("t2_flags", flags, 4'b1010);

    // 3. 0xFF + imm 0x01 into itself -> 0x00, Z=1 C=1; RD keeps flags
    issue(2'b10, 3'b000, 2'd1, 2'd0, 2'd0, 8'hFF, 1'b0, 1'b0);
    issue(2'b01, 3'b000, 2'd1, 2'd1, 2'd0, 8'h01, 1'b0, 1'b0);
    check("t3_data", res_data, 8'h00);
    check("t3_flags", flags, 4'b0101);
    issue(2'b11, 3'b000, 2'd0, 2'd1, 2'd0, 8'hAA, 1'b0, 1'b0);
    check("t3_rd_data", res_data, 8'h00);
    check("t3_rd_flags", flags, 4'b0101);

    // 4. valid held high across three instructions
    acc_q.delete();
    issue(2'b10, 3'b000, 2'd0, 2'd0, 2'd0, 8'h11, 1'b1, 1'b0);
    issue(2'b10, 3'b000, 2'd1, 2'd0, 2'd0, 8'h22, 1'b1, 1'b0);
    issue(2'b00, 3'b000, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0, 1'b0);
    check("t4_accepts", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check("t4_gap1", acc_q[1] - acc_q[0], 3);
      check("t4_gap2", acc_q[2] - acc_q[1], 3);
    end
    check("t4_data", res_data, 8'h33);

    // 5. logic op takes ALU C/V verbatim; LDI keeps V/C
    issue(2'b10, 3'b000, 2'd0, 2'd0, 2'd0, 8'h80, 1'b0, 1'b0);
    issue(2'b00, 3'b000, 2'd1, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0);
    check("t5_add_flags", flags, 4'b0111);
    issue(2'b00, 3'b100, 2'd2, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0);
    check("t5_and_data", res_data, 8'h80);
    check("t5_and_flags", flags, 4'b1000);
    issue(2'b00, 3'b000, 2'd1, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0);
    issue(2'b10, 3'b000, 2'd3, 2'd0, 2'd0, 8'h80, 1'b0, 1'b0);
    check("t5_ldi_flags", flags, 4'b1011);
    issue(2'b10, 3'b000, 2'd3, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0);
    check("t5_ldi0_flags", flags, 4'b0111);

    // randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        instr_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    instr_valid = 1'b0;

    // read back every register against the model
    for (int i = 0; i < 4; i++) issue(2'b11, 3'b000, 2'd0, 2'(i), 2'd0, 8'h00, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_exec_ctrl
